div_iter: RTL

Iterative 32-bit radix-2 restoring divider for the EX stage of the MIPS core, serving DIV and DIVU. It computes one quotient bit per cycle and produces the quotient and remainder for HI/LO writeback. Each iteration is a single 33-bit trial subtraction on the core's carry-lookahead adder: B operand inverted, cin=1, 33rd bit carried on the extension inputs. Control is a valid/ready handshake on both sides, plus a flush input for exceptions.

---
 rtl/div_iter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per cycle, with sign fix-up registered on the last CALC edge.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_valid,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             div_ready,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] origX;
  logic [WIDTH-1:0] prem;
  logic [WIDTH-1:0] quot;
  logic             qSign;
  logic             rSign;
  logic             yZero;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] premNext;
  logic [WIDTH-1:0] quotNext;
  logic [WIDTH-1:0] absX;
  logic [WIDTH-1:0] absY;
  logic             lastIter;

  assign div_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign lastIter  = (count == CW'(WIDTH - 1));

  assign absX = (div_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  assign absY = (div_signed && y[WIDTH-1]) ? (~y + WIDTH'(1)) : y;

  // Trial subtraction as A + ~B + 1; the dividend register is shifted so its MSB is bit 31-count.
  always_comb begin
    trial    = {prem, dividend[WIDTH-1]} + {1'b1, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
    premNext = {prem[WIDTH-2:0], dividend[WIDTH-1]};
    quotNext = {quot[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      premNext = trial[WIDTH-1:0];
      quotNext = {quot[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  // Cancel overrides both the accept and the result handshake.
  always_comb begin
    nextState = state;
    if (cancel) begin
      nextState = IDLE;
    end else begin
      case (state)
        IDLE:    if (div_valid) nextState = CALC;
        CALC:    if (lastIter)  nextState = DONE;
        DONE:    if (out_ready) nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      dividend <= '0;
      divisor  <= '0;
      origX    <= '0;
      prem     <= '0;
      quot     <= '0;
      qSign    <= 1'b0;
      rSign    <= 1'b0;
      yZero    <= 1'b0;
      s        <= '0;
      r        <= '0;
    end else if (cancel) begin
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (div_valid) begin
            dividend <= absX;
            divisor  <= absY;
            origX    <= x;
            qSign    <= div_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            rSign    <= div_signed & x[WIDTH-1];
            yZero    <= (y == '0);
            prem     <= '0;
            quot     <= '0;
            count    <= '0;
          end
        end
        CALC: begin
          prem     <= premNext;
          quot     <= quotNext;
          dividend <= {dividend[WIDTH-2:0], 1'b0};
          count    <= count + CW'(1);
          // Results are registered here so no negate sits on the output path.
          if (lastIter) begin
            if (yZero) begin
              s <= '1;
              r <= origX;
            end else begin
              s <= qSign ? (~quotNext + WIDTH'(1)) : quotNext;
              r <= rSign ? (~premNext + WIDTH'(1)) : premNext;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
